// File: rtl/ps2_rx_pkg.sv
// rtl/ps2_rx_pkg.sv - shared types and constants for the PS/2 keyboard receiver
package ps2_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } ps2_rx_state_t;

  // Prefix bytes folded into flags on the following scan code
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  // rel = preceded by F0 (release), ext = preceded by E0 (extended)
  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } ps2_code_t;

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - decoded scan code handshake between receiver and matrix logic
interface ps2_kbd_rx_if;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] code;
  logic       code_ext;
  logic       code_release;

  modport master (
    output code_valid,
    output code,
    output code_ext,
    output code_release,
    input  code_ready
  );

  modport slave (
    input  code_valid,
    input  code,
    input  code_ext,
    input  code_release,
    output code_ready
  );
endinterface

// File: rtl/ps2_code_fifo.sv
// rtl/ps2_code_fifo.sv - synchronous show-ahead FIFO of decoded scan codes
module ps2_code_fifo
  import ps2_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_48m,
  input  logic          reset,
  input  logic          push,
  input  ps2_code_t     push_data,
  input  logic          pop,
  output ps2_code_t     pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  ps2_code_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves on the same edge
  assign do_push = push & (~full | do_pop);
  // Head is forced to zero while empty so stale entries never leak out
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally; occupancy tracks push/pop balance
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, contents are don't-care until written
  always_ff @(posedge clk_48m) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard frame receiver with prefix folding and code FIFO
module ps2_kbd_rx
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk_48m,
  input  logic         reset,
  input  logic         ps2_clk,
  input  logic         ps2_dat,
  ps2_kbd_rx_if.master code_if,
  output logic         frame_err,
  output logic         overflow,
  input  logic         ovf_clr
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev, fall;
  logic [FW-1:0] filt_cnt;

  ps2_rx_state_t state_q, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          parity_ok;
  logic          err_d;

  logic          ext_pend, rel_pend;
  logic          push_q;
  ps2_code_t     push_data;
  ps2_code_t     head;
  logic          fifo_full, fifo_empty, pop;
  logic [CW-1:0] fifo_count;

  // Two-flop synchronisers; both lines idle high
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      {clk_s1, clk_s2, dat_s1, dat_s2} <= 4'b1111;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: flip the filtered clock only after FILTER_LEN steady samples
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // Registered falling-edge strobe of the filtered clock
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      filt_prev <= 1'b1;
      fall      <= 1'b0;
    end else begin
      filt_prev <= filt_clk;
      fall      <= filt_prev & ~filt_clk;
    end
  end

  // Odd parity over data byte plus parity bit
  assign parity_ok = ^{shift_q, par_q};
  // Counter reloads on each fall, so this fires TIMEOUT cycles after the last one
  assign to_hit    = ~fall & (to_cnt == TW'(TIMEOUT - 2));

  // Frame state register
  always_ff @(posedge clk_48m) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Frame next-state and error decision
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall && !dat_s2) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (fall) begin
          if (bit_cnt == 3'd7) state_d = ST_PARITY;
        end else if (to_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          state_d = ST_STOP;
        end else if (to_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (dat_s2 && parity_ok) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end else if (to_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit shifting, parity capture and inter-edge timeout counter
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (fall || state_q == ST_IDLE || state_q == ST_DONE) to_cnt <= '0;
      else                                                   to_cnt <= to_cnt + TW'(1);
      if (fall) begin
        case (state_q)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shift_q <= {dat_s2, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par_q <= dat_s2;
          default:   ;
        endcase
      end
    end
  end

  // Prefix folding and FIFO write request; errors drop any pending prefix
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      ext_pend  <= 1'b0;
      rel_pend  <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      frame_err <= err_d;
      if (err_d) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (state_q == ST_DONE) begin
        if (shift_q == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (shift_q == PS2_REL) begin
          rel_pend <= 1'b1;
        end else begin
          push_q    <= 1'b1;
          push_data <= {rel_pend, ext_pend, shift_q};
          ext_pend  <= 1'b0;
          rel_pend  <= 1'b0;
        end
      end
    end
  end

  assign pop = ~fifo_empty & code_if.code_ready;

  // Sticky overflow; a drop on the same cycle as a clear keeps it set
  always_ff @(posedge clk_48m) begin
    if (reset)                              overflow <= 1'b0;
    else if (push_q && fifo_full && !pop)   overflow <= 1'b1;
    else if (ovf_clr)                       overflow <= 1'b0;
  end

  ps2_code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_48m   (clk_48m),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign code_if.code_valid   = ~fifo_empty;
  assign code_if.code         = head.code;
  assign code_if.code_ext     = head.ext;
  assign code_if.code_release = head.rel;

  // Full flag and occupancy must agree
  a_fifo_count: assert property (@(posedge clk_48m) disable iff (reset)
    fifo_full == (fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - scoreboard bench for the PS/2 keyboard receiver
module tb_ps2_kbd_rx;
  import ps2_rx_pkg::*;

  localparam int F  = 8;
  localparam int TO = 9600;
  localparam int H  = 40;

  logic clk_48m = 1'b0;
  logic reset   = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic ovf_clr = 1'b0;
  logic frame_err, overflow;

  ps2_kbd_rx_if bus();

  ps2_kbd_rx #(.FILTER_LEN(F), .TIMEOUT(TO), .FIFO_DEPTH(4)) dut (
    .clk_48m   (clk_48m),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .code_if   (bus.master),
    .frame_err (frame_err),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #10 clk_48m = ~clk_48m;

  int cyc = 0;
  always @(posedge clk_48m) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];
  int   last_fall_cyc  = 0;
  int   valid_rise_cyc = -1;
  int   last_err_cyc   = 0;
  int   err_pulses     = 0;
  logic err_prev       = 1'b0;
  logic valid_prev     = 1'b0;
  bit   stop_seen      = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_48m);
    #1;
  endtask

  // Drive one frame (or its first nbits bits); data changes while the clock is high
  task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0,
                            input logic stop = 1'b1, input int nbits = 11);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      repeat (H) tick();
      ps2_clk = 1'b0;
      last_fall_cyc = cyc + 1;
      if (i == 10) stop_seen = 1'b1;
      repeat (H) tick();
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (2 * H) tick();
  endtask

  // Monitor: pops the scoreboard on every accepted head, tracks frame_err pulses
  always @(negedge clk_48m) begin
    if (!reset) begin
      if (bus.code_valid && !valid_prev) valid_rise_cyc = cyc;
      if (bus.code_valid && bus.code_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_code: actual=%0h required=none",
                   {bus.code_release, bus.code_ext, bus.code});
        end else begin
          chk("code_head", int'({bus.code_release, bus.code_ext, bus.code}),
              int'(exp_q.pop_front()));
        end
      end
      if (frame_err) begin
        if (err_prev) begin
          checks++;
          errors++;
          $display("FAIL frame_err_width: actual=>1 cycles required=1");
        end else begin
          err_pulses++;
          last_err_cyc = cyc;
        end
      end
      err_prev   = frame_err;
      valid_prev = bus.code_valid;
    end else begin
      err_prev   = 1'b0;
      valid_prev = 1'b0;
    end
  end

  initial begin
    bus.code_ready = 1'b1;
    repeat (5) tick();
    chk("rst_valid",   int'(bus.code_valid),   0);
    chk("rst_code",    int'(bus.code),         0);
    chk("rst_ext",     int'(bus.code_ext),     0);
    chk("rst_rel",     int'(bus.code_release), 0);
    chk("rst_ferr",    int'(frame_err),        0);
    chk("rst_ovf",     int'(overflow),         0);
    chk("rst_state",   int'(dut.state_q),      int'(ST_IDLE));
    reset = 1'b0;
    repeat (4) tick();

    // Plain make code and latency from the stop-bit edge
    exp_q.push_back(10'h01C);
    send_frame(8'h1C);
    chk("latency", valid_rise_cyc - last_fall_cyc, F + 5);
    chk("no_err_basic", err_pulses, 0);

    // Extended release, then plain repeat
    exp_q.push_back(10'h375);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    exp_q.push_back(10'h075);
    send_frame(8'h75);

    // Errors discard frames and any pending prefix
    send_frame(8'hF0);
    send_frame(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("err_two_pulses", err_pulses, 2);
    chk("err_fifo_empty", int'(bus.code_valid), 0);
    exp_q.push_back(10'h01C);
    send_frame(8'h1C);
    exp_q.push_back(10'h21C);
    send_frame(8'hF0);
    send_frame(8'h1C);

    // Timeout after a partial frame
    send_frame(8'hA5, 1'b0, 1'b1, 5);
    for (int k = 0; k < 12000 && err_pulses < 3; k++) tick();
    chk("timeout_err", err_pulses, 3);
    chk("timeout_delay", last_err_cyc - last_fall_cyc, F + 2 + TO);
    chk("timeout_idle", int'(dut.state_q), int'(ST_IDLE));
    exp_q.push_back(10'h05A);
    send_frame(8'h5A);

    // Overflow: fifth code dropped
    bus.code_ready = 1'b0;
    exp_q.push_back(10'h001);
    exp_q.push_back(10'h002);
    exp_q.push_back(10'h003);
    exp_q.push_back(10'h004);
    send_frame(8'h01);
    send_frame(8'h02);
    send_frame(8'h03);
    send_frame(8'h04);
    send_frame(8'h05);
    chk("ovf_set",  int'(overflow), 1);
    chk("ovf_head", int'(bus.code), 8'h01);
    bus.code_ready = 1'b1;
    repeat (10) tick();
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_sticky",  int'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    chk("ovf_cleared", int'(overflow), 0);

    // Push into a full FIFO on the same edge as a pop
    bus.code_ready = 1'b0;
    for (int v = 1; v <= 5; v++) exp_q.push_back(10'(v));
    send_frame(8'h01);
    send_frame(8'h02);
    send_frame(8'h03);
    send_frame(8'h04);
    stop_seen = 1'b0;
    fork
      send_frame(8'h05);
      begin
        wait (stop_seen);
        while (cyc < last_fall_cyc + F + 4) tick();
        bus.code_ready = 1'b1;
        tick();
        bus.code_ready = 1'b0;
      end
    join
    chk("full_pop_push_ovf", int'(overflow), 0);
    bus.code_ready = 1'b1;
    repeat (10) tick();
    chk("full_pop_push_drained", exp_q.size(), 0);

    // Short low glitch while idle is ignored
    ps2_clk = 1'b0;
    repeat (3) tick();
    ps2_clk = 1'b1;
    repeat (30) tick();
    chk("glitch_idle",  int'(dut.state_q), int'(ST_IDLE));
    chk("glitch_noerr", err_pulses, 3);
    chk("glitch_noout", int'(bus.code_valid), 0);

    // Reset mid-frame drops FIFO contents, pending prefix and partial frame
    bus.code_ready = 1'b0;
    send_frame(8'h33);
    send_frame(8'hF0);
    send_frame(8'h12, 1'b0, 1'b1, 6);
    reset = 1'b1;
    repeat (3) tick();
    chk("mid_rst_valid", int'(bus.code_valid), 0);
    chk("mid_rst_code",  int'(bus.code),       0);
    chk("mid_rst_ovf",   int'(overflow),       0);
    chk("mid_rst_ferr",  int'(frame_err),      0);
    chk("mid_rst_state", int'(dut.state_q),    int'(ST_IDLE));
    reset = 1'b0;
    bus.code_ready = 1'b1;
    repeat (4) tick();
    exp_q.push_back(10'h01C);
    send_frame(8'h1C);
    repeat (20) tick();
    chk("final_drained", exp_q.size(), 0);
    chk("final_errs",    err_pulses, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
